// File: rtl/model_nexys_hls4ml_prj_1_dense_acc_relu_pkg.sv
// Shared definitions for the dense accumulate / ReLU output stage.
//   dense_state_e : frame-level control states (idle, accumulating, holding result)
//   cnt_width     : bits needed to count 0..n_terms inclusive
package model_nexys_hls4ml_prj_1_dense_acc_relu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } dense_state_e;

    // Counter reaches n_terms on the final accept, so it must hold n_terms itself.
    function automatic int unsigned cnt_width(input int unsigned n_terms);
        return $clog2(n_terms + 1);
    endfunction

endpackage

// File: rtl/model_nexys_hls4ml_prj_1_relu_sat.sv
// Combinational rescale + ReLU + unsigned saturation.
//   acc_i : signed accumulator value
//   res_o : floor(acc_i / 2^SHIFT) clamped to [0, 2^OUT_WIDTH-1]
module model_nexys_hls4ml_prj_1_relu_sat #(
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned SHIFT     = 8,
    parameter int unsigned OUT_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0] acc_i,
    output logic        [OUT_WIDTH-1:0] res_o
);

    logic signed [ACC_WIDTH-1:0] shifted;
    logic        [ACC_WIDTH-1:0] upper;

    // Arithmetic shift gives floor division for negative values.
    assign shifted = acc_i >>> SHIFT;
    // Any set bit above the output range means the value exceeds the max code.
    assign upper   = $unsigned(shifted) >> OUT_WIDTH;

    always_comb begin
        res_o = '0;
        if (shifted[ACC_WIDTH-1]) begin
            res_o = '0;
        end else if (|upper) begin
            res_o = '1;
        end else begin
            res_o = OUT_WIDTH'($unsigned(shifted));
        end
    end

endmodule

// File: rtl/model_nexys_hls4ml_prj_1_dense_acc_relu.sv
// Dense-layer neuron back end: accumulates N_TERMS signed products plus a bias,
// rescales, applies ReLU with saturation and presents the result on valid/ready.
//   clk, reset           : clock, asynchronous active-high reset
//   prod_valid/ready/data: product input handshake
//   bias                 : signed bias, taken with the first product of a frame
//   out_valid/ready/data : registered result handshake
//   busy                 : frame partially accumulated
module model_nexys_hls4ml_prj_1_dense_acc_relu
    import model_nexys_hls4ml_prj_1_dense_acc_relu_pkg::*;
#(
    parameter int unsigned N_TERMS    = 16,
    parameter int unsigned PROD_WIDTH = 22,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned SHIFT      = 8,
    parameter int unsigned OUT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic [PROD_WIDTH-1:0] bias,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  busy
);

    localparam int unsigned      CNT_W    = cnt_width(N_TERMS);
    localparam int unsigned      EXT_W    = ACC_WIDTH - PROD_WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);

    dense_state_e                state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic        [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;

    logic signed [ACC_WIDTH-1:0] prod_sext;
    logic signed [ACC_WIDTH-1:0] bias_sext;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic        [OUT_WIDTH-1:0] sat_res;
    logic                        accept;

    assign prod_sext = {{EXT_W{prod_data[PROD_WIDTH-1]}}, prod_data};
    assign bias_sext = {{EXT_W{bias[PROD_WIDTH-1]}}, bias};
    assign accept    = prod_valid && prod_ready;

    // First product of a frame starts from the bias instead of the old accumulator.
    assign acc_sum = (state_q == ST_IDLE) ? (bias_sext + prod_sext) : (acc_q + prod_sext);

    // Result is derived from the sum being written, so it is ready one cycle after the last accept.
    model_nexys_hls4ml_prj_1_relu_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_relu_sat (
        .acc_i (acc_sum),
        .res_o (sat_res)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = CNT_W'(1);
                    if (N_TERMS == 1) begin
                        state_d     = ST_OUTPUT;
                        out_data_d  = sat_res;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d     = ST_OUTPUT;
                        out_data_d  = sat_res;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign prod_ready = (state_q != ST_OUTPUT);
    assign busy       = (state_q == ST_ACCUM);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;

endmodule

// File: tb/tb_model_nexys_hls4ml_prj_1_dense_acc_relu.sv
module tb_model_nexys_hls4ml_prj_1_dense_acc_relu;

    localparam int unsigned N_TERMS    = 4;
    localparam int unsigned PROD_WIDTH = 22;
    localparam int unsigned ACC_WIDTH  = 32;
    localparam int unsigned SHIFT      = 4;
    localparam int unsigned OUT_WIDTH  = 16;

    logic                  clk;
    logic                  reset;
    logic                  prod_valid;
    logic                  prod_ready;
    logic [PROD_WIDTH-1:0] prod_data;
    logic [PROD_WIDTH-1:0] bias;
    logic                  out_valid;
    logic                  out_ready;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  busy;

    int n_checks = 0;
    int n_fail   = 0;

    model_nexys_hls4ml_prj_1_dense_acc_relu #(
        .N_TERMS    (N_TERMS),
        .PROD_WIDTH (PROD_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT      (SHIFT),
        .OUT_WIDTH  (OUT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .bias       (bias),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: integer sum, floor-divide by 2^SHIFT, clamp to the unsigned output range.
    function automatic int ref_out(input int b, input int pr[4]);
        longint s;
        longint maxv;
        s = longint'(b);
        for (int i = 0; i < 4; i++) s += longint'(pr[i]);
        s = s >>> SHIFT;
        maxv = (longint'(1) << OUT_WIDTH) - 1;
        if (s < 0) return 0;
        if (s > maxv) return int'(maxv);
        return int'(s);
    endfunction

    // gap: 0 back-to-back, 1 idle cycle before every product, 2 random idle cycles.
    // hold: cycles out_ready is held low once the result is presented.
    task automatic run_frame(input int b, input int pr[4], input int gap, input int hold,
                             input string tag);
        int exp;
        exp = ref_out(b, pr);
        out_ready = (hold == 0);
        for (int i = 0; i < 4; i++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
                prod_valid = 1'b0;
                @(negedge clk);
                if (i > 0) chk({tag, "_busy_gap"}, 32'(busy), 32'd1);
            end
            prod_valid = 1'b1;
            prod_data  = PROD_WIDTH'(pr[i]);
            bias       = PROD_WIDTH'(b);
            chk({tag, "_prod_ready"}, 32'(prod_ready), 32'd1);
            @(negedge clk);
            if (i < 3) chk({tag, "_busy"}, 32'(busy), 32'd1);
        end
        prod_valid = 1'b0;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out_data"}, 32'(out_data), 32'(exp));
        chk({tag, "_busy_out"}, 32'(busy), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_data"}, 32'(out_data), 32'(exp));
            chk({tag, "_hold_ready"}, 32'(prod_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_after_hs_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_after_hs_ready"}, 32'(prod_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        int pr[4];
        int b;
        reset      = 1'b1;
        prod_valid = 1'b0;
        prod_data  = '0;
        bias       = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_prod_ready", 32'(prod_ready), 32'd1);

        pr = '{16, 32, 48, 64};
        run_frame(0, pr, 0, 0, "b2b");
        chk("b2b_value", 32'(ref_out(0, pr)), 32'd10);

        pr = '{-100, -100, -100, -100};
        run_frame(50, pr, 0, 0, "neg");

        pr = '{2097151, 2097151, 2097151, 2097151};
        run_frame(0, pr, 0, 0, "sat");

        pr = '{160, 160, 160, 160};
        run_frame(0, pr, 0, 5, "bp");

        // Partial frame discarded by reset.
        prod_valid = 1'b1;
        prod_data  = PROD_WIDTH'(1000);
        bias       = PROD_WIDTH'(500);
        @(negedge clk);
        prod_data  = PROD_WIDTH'(2000);
        @(negedge clk);
        prod_valid = 1'b0;
        chk("midrst_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        pr = '{16, 32, 48, 64};
        run_frame(0, pr, 0, 0, "midrst");

        run_frame(0, pr, 1, 0, "toggle");

        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 4; i++) pr[i] = int'($urandom_range(0, 4194303)) - 2097152;
            b = int'($urandom_range(0, 4194303)) - 2097152;
            run_frame(b, pr, 2, int'($urandom_range(0, 3)), $sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
